// File: rtl/msx_kbd_pkg.sv
// ---------------------------------------------------------------------------
// msx_kbd_pkg
// Types shared by both halves of the MSX keyboard path: the matrix register
// that consumes key codes and the matrix scanner that produces them.
//   MSX_ROWS / MSX_COLS : geometry of the MSX keyboard matrix
//   key_code_t          : {row[3:0], col[2:0]}, identical to keyMatrix coding
//   kbd_evt_t           : key code plus break flag (1 = release, 0 = press)
//   scan_state_t        : scanner FSM states
//   lowest_set_bit      : priority encoder, index of the lowest set bit
// ---------------------------------------------------------------------------
package msx_kbd_pkg;

   localparam int MSX_ROWS = 11;
   localparam int MSX_COLS = 8;

   typedef struct packed {
      logic [3:0] row;
      logic [2:0] col;
   } key_code_t;

   typedef struct packed {
      key_code_t code;
      logic      brk;
   } kbd_evt_t;

   typedef enum logic [2:0] {
      S_SELECT,
      S_SETTLE,
      S_SAMPLE,
      S_EMIT,
      S_NEXT
   } scan_state_t;

   // Scanning downwards means the last hit is the lowest set bit, so that is
   // the column handled first and changes leave in ascending column order.
   function automatic logic [2:0] lowest_set_bit(input logic [7:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/msx_evt_fifo.sv
// ---------------------------------------------------------------------------
// msx_evt_fifo
// Synchronous first-word-fall-through FIFO for keyboard events.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_data when not full
//   push_data : event to store
//   full      : no free entry (registered occupancy, a same-cycle pop does
//               not free the slot until the next cycle)
//   pop       : drop head entry when not empty
//   pop_data  : current head entry, valid whenever empty is low
//   empty     : no entry stored
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module msx_evt_fifo
   import msx_kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  kbd_evt_t push_data,
   output logic     full,
   input  logic     pop,
   output kbd_evt_t pop_data,
   output logic     empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   kbd_evt_t    mem_q [DEPTH];
   kbd_evt_t    mem_d [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;

   // Pointers carry one extra wrap bit so equal indices can be told apart
   // as either empty (same wrap) or full (opposite wrap).
   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_data = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && !full) begin
         mem_d[wr_q[AW-1:0]] = push_data;
         wr_d = wr_q + PTR_ONE;
      end
      if (pop && !empty) begin
         rd_d = rd_q + PTR_ONE;
      end
   end

   // Storage is cleared on reset so the head shows an all-zero event
   // while the FIFO is still untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

endmodule

// File: rtl/msx_matrix_scanner.sv
// ---------------------------------------------------------------------------
// msx_matrix_scanner
// Scans a physical MSX keyboard matrix and turns every key change into a
// make/break event coded {row[3:0], col[2:0]} plus a break flag.
//   CLK, RST  : clock, asynchronous active-high reset
//   scan_en   : 1 = scan runs, 0 = finish the current row then hold in SELECT
//   Y         : row select driven to the matrix
//   X         : active-low column bus (0 = pressed), already synchronised
//   evt_valid : event FIFO head is valid
//   evt_ready : consumer takes the head when evt_valid & evt_ready
//   evt_code  : {row, col} of the head event
//   evt_break : 1 = release, 0 = press
//   fifo_ovf  : sticky, set if a push were ever attempted into a full FIFO
// Build option SCAN_DEBOUNCE_EN: a column change is reported only when the
// same row value was seen on two consecutive scans.
// ---------------------------------------------------------------------------
module msx_matrix_scanner
   import msx_kbd_pkg::*;
#(
   parameter int NUM_ROWS   = MSX_ROWS,
   parameter int SETTLE_CYC = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       scan_en,
   output logic [3:0] Y,
   input  logic [7:0] X,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [6:0] evt_code,
   output logic       evt_break,
   output logic       fifo_ovf
);

   localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       ROW_LAST = 4'(NUM_ROWS - 1);

   scan_state_t                state_q, state_d;
   logic [3:0]                 row_q, row_d;
   logic [3:0]                 y_q, y_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [7:0]                 smp_q, smp_d;
   logic [NUM_ROWS-1:0][7:0]   kimg_q, kimg_d;
   logic                       ovf_q, ovf_d;

   logic [7:0] diff;
   logic [2:0] col;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   kbd_evt_t   push_evt;
   kbd_evt_t   head_evt;

   // Bits still to report for the row under EMIT. With debouncing, a bit
   // only counts when this scan's sample agrees with the previous scan's.
`ifdef SCAN_DEBOUNCE_EN
   logic [NUM_ROWS-1:0][7:0] prev_q, prev_d;
   assign diff = (smp_q ^ kimg_q[row_q]) & ~(smp_q ^ prev_q[row_q]);
`else
   assign diff = smp_q ^ kimg_q[row_q];
`endif

   assign col = lowest_set_bit(diff);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      smp_d    = smp_q;
      kimg_d   = kimg_q;
`ifdef SCAN_DEBOUNCE_EN
      prev_d   = prev_q;
`endif
      push     = 1'b0;
      push_evt = '0;
      case (state_q)
         S_SELECT: begin
            y_d = row_q;
            if (scan_en) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
            else                   cnt_d   = cnt_q + CNT_ONE;
         end
         S_SAMPLE: begin
            smp_d   = X;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            // One change per cycle; a full FIFO simply holds everything
            // (including the key image) until a slot opens.
            if (diff == 8'h00) begin
`ifdef SCAN_DEBOUNCE_EN
               prev_d[row_q] = smp_q;
`endif
               state_d = S_NEXT;
            end else if (!fifo_full) begin
               push                = 1'b1;
               push_evt.code.row   = row_q;
               push_evt.code.col   = col;
               push_evt.brk        = smp_q[col];
               kimg_d[row_q][col]  = smp_q[col];
            end
         end
         S_NEXT: begin
            row_d   = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
            state_d = S_SELECT;
         end
         default: state_d = S_SELECT;
      endcase
      ovf_d = ovf_q | (push & fifo_full);
   end

   // Key image starts as all released, so keys held through a reset come
   // back out as make events on the first scan afterwards.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_SELECT;
         row_q   <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         smp_q   <= '1;
         kimg_q  <= '1;
`ifdef SCAN_DEBOUNCE_EN
         prev_q  <= '1;
`endif
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         smp_q   <= smp_d;
         kimg_q  <= kimg_d;
`ifdef SCAN_DEBOUNCE_EN
         prev_q  <= prev_d;
`endif
         ovf_q   <= ovf_d;
      end
   end

   assign pop = evt_valid & evt_ready;

   msx_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_data (push_evt),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (head_evt),
      .empty     (fifo_empty)
   );

   assign Y         = y_q;
   assign evt_valid = ~fifo_empty;
   assign evt_code  = head_evt.code;
   assign evt_break = head_evt.brk;
   assign fifo_ovf  = ovf_q;

endmodule
